// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-port arbiter, its two requesters and RAM port 1.
// slave  : the arbiter's view (requests and mem_q in; grants, read data and RAM controls out).
// master : the environment's view (requesters plus the RAM model).
interface dmem_port_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
);
    logic              m0_req;
    logic              m0_we;
    logic [AWIDTH-1:0] m0_addr;
    logic [DWIDTH-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DWIDTH-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [AWIDTH-1:0] m1_addr;
    logic [DWIDTH-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DWIDTH-1:0] m1_rdata;

    logic [AWIDTH-1:0] mem_addr;
    logic              mem_we;
    logic [DWIDTH-1:0] mem_d;
    logic [DWIDTH-1:0] mem_q;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_q,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_we, mem_d, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_q,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_we, mem_d, busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares RAM data port 1 between the load/store unit (m0)
// and the loader/debug master (m1). Two-state FSM: IDLE picks a winner and
// latches its command, ACCESS drives the RAM for exactly one cycle and
// captures read data at its closing edge.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking;
// otherwise m0 always wins a tie (fixed priority).
module dmem_port_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]        state_q,     state_d;
    logic              cmd_we_q,    cmd_we_d;
    logic [AWIDTH-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DWIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              cmd_src_q,   cmd_src_d;
    logic              last_gnt_q,  last_gnt_d;
    logic              m0_gnt_q,    m0_gnt_d;
    logic              m1_gnt_q,    m1_gnt_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DWIDTH-1:0] m0_rdata_q,  m0_rdata_d;
    logic [DWIDTH-1:0] m1_rdata_q,  m1_rdata_d;
    logic              win_s;

    // Pick the requester to serve this cycle (only meaningful when some req is high)
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        if (bus.m0_req && bus.m1_req) begin
            win_s = ~last_gnt_q;
        end else if (bus.m0_req) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`else
        if (bus.m0_req) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`endif
    end

    // Next-state logic: grant and latch in IDLE, perform the RAM cycle in ACCESS
    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_src_d   = cmd_src_q;
        last_gnt_d  = last_gnt_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d    = ST_ACCESS;
                    cmd_src_d  = win_s;
                    last_gnt_d = win_s;
                    if (win_s == 1'b0) begin
                        cmd_we_d    = bus.m0_we;
                        cmd_addr_d  = bus.m0_addr;
                        cmd_wdata_d = bus.m0_wdata;
                        m0_gnt_d    = 1'b1;
                    end else begin
                        cmd_we_d    = bus.m1_we;
                        cmd_addr_d  = bus.m1_addr;
                        cmd_wdata_d = bus.m1_wdata;
                        m1_gnt_d    = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Requests are ignored here; the RAM read data is sampled at the closing edge.
                state_d = ST_IDLE;
                if (!cmd_we_q) begin
                    if (cmd_src_q == 1'b0) begin
                        m0_rvalid_d = 1'b1;
                        m0_rdata_d  = bus.mem_q;
                    end else begin
                        m1_rvalid_d = 1'b1;
                        m1_rdata_d  = bus.mem_q;
                    end
                end else begin
                    m0_rvalid_d = 1'b0;
                    m1_rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and command registers; last_gnt resets to m1 so m0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= {AWIDTH{1'b0}};
            cmd_wdata_q <= {DWIDTH{1'b0}};
            cmd_src_q   <= 1'b0;
            last_gnt_q  <= 1'b1;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= {DWIDTH{1'b0}};
            m1_rdata_q  <= {DWIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_src_q   <= cmd_src_d;
            last_gnt_q  <= last_gnt_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // Outputs come straight from flops; mem_we is gated by the ACCESS state so a
    // reset inside ACCESS removes the write strobe before the closing edge.
    assign bus.m0_gnt    = m0_gnt_q;
    assign bus.m1_gnt    = m1_gnt_q;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.mem_addr  = cmd_addr_q;
    assign bus.mem_d     = cmd_wdata_q;
    assign bus.mem_we    = (state_q == ST_ACCESS) && cmd_we_q;
    assign bus.busy      = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter. The driver issues commands and, at the same
// time, a transaction-level reference model decides which access is served on
// which cycle and pushes the expected grant / read-data events into a queue.
// An independent monitor pops those events on every falling edge and compares
// them with what the DUT presents. A simple asynchronous-read RAM sits on port 1.
module tb_dmem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;

    typedef struct {
        int          cyc;   // cycle in which the event must be visible
        bit          m;     // requester index
        bit          rv;    // 0: grant/access event, 1: read-data event
        bit          we;
        logic [11:0] a;
        logic [31:0] d;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    dmem_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    dmem_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM port 1: asynchronous read, write at the rising edge
    logic [31:0] ram [0:4095];
    assign bus.mem_q = ram[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_d;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state
    logic [31:0] model_mem [0:4095];
    bit          last_w;
    int          acc_cyc;
    bit          acc_wr;
    logic [11:0] acc_addr;
    logic [31:0] acc_old;
    ev_t         exp_q [$];
    logic [11:0] h_addr;
    logic [31:0] h_d;
    logic [31:0] h_rd [2];
    int          gnt_log [$];

    bit          pend_v  [2];
    bit          pend_we [2];
    logic [11:0] pend_a  [2];
    logic [31:0] pend_wd [2];

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return {20'hC0DE0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_pins();
        bus.m0_req   = pend_v[0];
        bus.m0_we    = pend_we[0];
        bus.m0_addr  = pend_a[0];
        bus.m0_wdata = pend_wd[0];
        bus.m1_req   = pend_v[1];
        bus.m1_we    = pend_we[1];
        bus.m1_addr  = pend_a[1];
        bus.m1_wdata = pend_wd[1];
    endtask

    task automatic issue(input int m, input bit we, input logic [11:0] a, input logic [31:0] d);
        pend_v[m]  = 1'b1;
        pend_we[m] = we;
        pend_a[m]  = a;
        pend_wd[m] = d;
    endtask

    // One cycle: present requests, then let the model decide what the port does next.
    // Port is free unless the coming cycle's predecessor is an ACCESS cycle.
    task automatic tick();
        ev_t e;
        bit  w;
        @(negedge clk);
        apply_pins();
        if (!rst && cyc != acc_cyc && (pend_v[0] || pend_v[1])) begin
            if (pend_v[0] && pend_v[1]) begin
`ifdef DMEM_ARB_RR_EN
                w = !last_w;
`else
                w = 1'b0;
`endif
            end else begin
                w = pend_v[1];
            end
            acc_cyc = cyc + 1;
            e.cyc = cyc + 1; e.m = w; e.rv = 1'b0; e.we = pend_we[w];
            e.a = pend_a[w]; e.d = pend_wd[w];
            exp_q.push_back(e);
            acc_wr = pend_we[w];
            if (pend_we[w]) begin
                acc_addr = pend_a[w];
                acc_old  = model_mem[pend_a[w]];
                model_mem[pend_a[w]] = pend_wd[w];
            end else begin
                e.cyc = cyc + 2; e.rv = 1'b1; e.we = 1'b0;
                e.d = model_mem[pend_a[w]];
                exp_q.push_back(e);
            end
            last_w = w;
            pend_v[w] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend_v[0] || pend_v[1] || exp_q.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        check("drain_bound", (n < 60) ? 32'd1 : 32'd0, 32'd1);
        tick();
    endtask

    // Reset asserted in the middle of a cycle; outputs must clear at once.
    // If it lands in a write ACCESS cycle, that write never reaches the RAM.
    task automatic reset_mid(input bit at_access);
        if (at_access) @(posedge clk);
        #2;
        rst = 1'b1;
        if (cyc == acc_cyc && acc_wr) model_mem[acc_addr] = acc_old;
        exp_q.delete();
        last_w  = 1'b1;
        acc_cyc = -10;
        h_addr  = 12'h000;
        h_d     = 32'h0;
        h_rd[0] = 32'h0;
        h_rd[1] = 32'h0;
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        apply_pins();
        #1;
        check("rst_m0_gnt",    {31'd0, bus.m0_gnt},    32'd0);
        check("rst_m1_gnt",    {31'd0, bus.m1_gnt},    32'd0);
        check("rst_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd0);
        check("rst_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
        check("rst_m0_rdata",  bus.m0_rdata,           32'd0);
        check("rst_m1_rdata",  bus.m1_rdata,           32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
        check("rst_mem_addr",  {20'd0, bus.mem_addr},  32'd0);
        check("rst_mem_d",     bus.mem_d,              32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare every output against the expected events for this cycle
    always @(negedge clk) begin
        bit  e_g [2];
        bit  e_r [2];
        bit  e_we;
        bit  e_busy;
        ev_t e;
        e_g[0] = 1'b0; e_g[1] = 1'b0; e_r[0] = 1'b0; e_r[1] = 1'b0;
        e_we = 1'b0; e_busy = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (!e.rv) begin
                e_g[e.m] = 1'b1;
                e_busy   = 1'b1;
                e_we     = e.we;
                h_addr   = e.a;
                h_d      = e.d;
            end else begin
                e_r[e.m]  = 1'b1;
                h_rd[e.m] = e.d;
            end
        end
        if (bus.m0_gnt) gnt_log.push_back(0);
        if (bus.m1_gnt) gnt_log.push_back(1);
        check("m0_gnt",    {31'd0, bus.m0_gnt},    {31'd0, e_g[0]});
        check("m1_gnt",    {31'd0, bus.m1_gnt},    {31'd0, e_g[1]});
        check("m0_rvalid", {31'd0, bus.m0_rvalid}, {31'd0, e_r[0]});
        check("m1_rvalid", {31'd0, bus.m1_rvalid}, {31'd0, e_r[1]});
        check("gnt_onehot",    {31'd0, bus.m0_gnt && bus.m1_gnt},       32'd0);
        check("rvalid_onehot", {31'd0, bus.m0_rvalid && bus.m1_rvalid}, 32'd0);
        check("busy",      {31'd0, bus.busy},      {31'd0, e_busy});
        check("mem_we",    {31'd0, bus.mem_we},    {31'd0, e_we});
        check("mem_addr",  {20'd0, bus.mem_addr},  {20'd0, h_addr});
        check("mem_d",     bus.mem_d,              h_d);
        check("m0_rdata",  bus.m0_rdata,           h_rd[0]);
        check("m1_rdata",  bus.m1_rdata,           h_rd[1]);
    end

    // Stimulus
    initial begin
        int          r;
        logic [11:0] a;
        logic [31:0] exp_g;
        for (int i = 0; i < 4096; i++) begin
            ram[i]       = init_val(12'(i));
            model_mem[i] = init_val(12'(i));
        end
        last_w = 1'b1; acc_cyc = -10; acc_wr = 1'b0; acc_addr = 12'h000; acc_old = 32'h0;
        h_addr = 12'h000; h_d = 32'h0; h_rd[0] = 32'h0; h_rd[1] = 32'h0;
        for (int m = 0; m < 2; m++) begin
            pend_v[m] = 1'b0; pend_we[m] = 1'b0; pend_a[m] = 12'h000; pend_wd[m] = 32'h0;
        end
        rst = 1'b1;
        apply_pins();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // m0 write then read back of 0x100
        issue(0, 1'b1, 12'h100, 32'hFFFF_FFFF);
        drain();
        issue(0, 1'b0, 12'h100, 32'h0);
        drain();
        check("t2_m0_rdata", bus.m0_rdata, 32'hFFFF_FFFF);

        // m1 writes 0x101, m0 reads it back
        issue(1, 1'b1, 12'h101, 32'hFFFF_CAFE);
        drain();
        issue(0, 1'b0, 12'h101, 32'h0);
        drain();
        check("t3_m0_rdata", bus.m0_rdata, 32'hFFFF_CAFE);

        // Reset in the middle of a cycle while a read is being granted
        issue(1, 1'b0, 12'h100, 32'h0);
        tick();
        reset_mid(1'b0);
        tick();

        // Both masters hold read requests for 8 cycles
        gnt_log.delete();
        for (int i = 0; i < 8; i++) begin
            if (!pend_v[0]) issue(0, 1'b0, 12'h100, 32'h0);
            if (!pend_v[1]) issue(1, 1'b0, 12'h101, 32'h0);
            tick();
        end
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        drain();
        check("t4_gnt_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_g = 32'(i % 2);
`else
            exp_g = 32'd0;
`endif
            check("t4_gnt_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, exp_g);
        end

        // Reset inside the ACCESS cycle of a write: the write must be lost
        issue(0, 1'b1, 12'h102, 32'h1234_5678);
        tick();
        reset_mid(1'b1);
        tick();
        issue(0, 1'b0, 12'h102, 32'h0);
        drain();
        check("t5_not_written", {31'd0, bus.m0_rdata != 32'h1234_5678}, 32'd1);
        check("t5_m0_rdata", bus.m0_rdata, init_val(12'h102));

        // Read of the unwritten location by m1
        issue(1, 1'b0, 12'h102, 32'h0);
        drain();
        check("t6_m1_rdata", bus.m1_rdata, init_val(12'h102));

        // Random traffic on a small address window plus the top address
        for (int i = 0; i < 600; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (pend_v[m]) begin
                    if ($urandom_range(15, 0) == 0) pend_v[m] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    r = $urandom_range(8, 0);
                    a = (r == 8) ? 12'hFFF : 12'h0FC + 12'(r);
                    issue(m, 1'($urandom_range(1, 0)), a, $urandom);
                end
            end
            tick();
        end
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
